// File: rtl/mdio_responder.sv
// -----------------------------------------------------------------------------
// mdio_responder
//
// PHY-side Clause 22 MDIO management responder. It holds a 32 x 16-bit register
// file, decodes read/write frames addressed to PHY_ADDR and drives read data
// back on MDIO. The pad tristate is resolved one level up from mdio_o/mdio_oe.
// Everything runs on the MDC clock (clk_25_mhz); MDIO is sampled on its rising
// edge.
//
// Ports:
//   clk_25_mhz  in   MDC clock
//   rst_n       in   asynchronous active-low reset
//   mdio_i      in   MDIO line as seen from the pad
//   mdio_o      out  MDIO drive value (idles at 1)
//   mdio_oe     out  MDIO output enable, 1 = responder drives
//   wr_strobe   out  one-cycle pulse after an accepted MDIO write
//   wr_addr     out  register address of the last accepted MDIO write
//   wr_data     out  data of the last accepted MDIO write
//   loc_addr    in   local read/write address
//   loc_rdata   out  combinational read of reg[loc_addr]
//   loc_we      in   local write enable (status bits such as link)
//   loc_wdata   in   local write data
//
// Optional feature macro: MDIO_PREAMBLE_SUPPRESS_EN
//   Defined   - a single 1 before ST is enough to start a frame, so masters
//               that suppress the preamble after the first frame are accepted.
//   Undefined - PREAMBLE_LEN consecutive 1s are required before ST.
//
// Registers 2 and 3 are read-only identifiers (PHY_ID1 / PHY_ID2); both MDIO
// and local writes to them are ignored.
// -----------------------------------------------------------------------------
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter logic [15:0] PHY_ID1      = 16'h0007,
    parameter logic [15:0] PHY_ID2      = 16'hC0F1,
    parameter int          PREAMBLE_LEN = 32
) (
    input  logic        clk_25_mhz,
    input  logic        rst_n,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    input  logic [4:0]  loc_addr,
    output logic [15:0] loc_rdata,
    input  logic        loc_we,
    input  logic [15:0] loc_wdata
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ST2     = 3'd1;
    localparam logic [2:0] S_OP      = 3'd2;
    localparam logic [2:0] S_PHYAD   = 3'd3;
    localparam logic [2:0] S_REGAD   = 3'd4;
    localparam logic [2:0] S_TA      = 3'd5;
    localparam logic [2:0] S_RD_DATA = 3'd6;
    localparam logic [2:0] S_WR_DATA = 3'd7;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam int PRE_THR = 1;
`else
    localparam int PRE_THR = PREAMBLE_LEN;
`endif
    localparam int               PRE_W   = $clog2(PREAMBLE_LEN + 1);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_THR);

    logic [2:0]       state_reg;
    logic [PRE_W-1:0] pre_cnt_reg;
    logic [4:0]       bit_cnt_reg;
    logic             op_msb_reg;
    logic             is_read_reg;
    logic [4:0]       phyad_reg;
    logic [4:0]       regad_reg;
    logic [15:0]      shift_reg;
    logic             oe_reg;
    logic             o_reg;
    logic             strobe_reg;
    logic [4:0]       wr_addr_reg;
    logic [15:0]      wr_data_reg;

    logic [15:0]      regs [32];
    logic [31:0]      row_we;
    logic [31:0][15:0] row_wdata;

    logic             addr_match;
    logic             mdio_we;
    logic [15:0]      mdio_wdata;
    logic [15:0]      regad_word;

    assign mdio_o    = o_reg;
    assign mdio_oe   = oe_reg;
    assign wr_strobe = strobe_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;

    // phyad_reg is stable from REGAD onward, which is the only time this is used.
    assign addr_match = (phyad_reg == PHY_ADDR);

    // The last data bit is still on mdio_i on the accepting edge, so the write
    // word is assembled from the shift register plus the live bit.
    assign mdio_wdata = {shift_reg[14:0], mdio_i};
    assign mdio_we    = (state_reg == S_WR_DATA) && (bit_cnt_reg == 5'd15) &&
                        addr_match && (regad_reg != 5'd2) && (regad_reg != 5'd3);

    // Register read mux with the identifier registers overlaid.
    always_comb begin
        regad_word = regs[regad_reg];
        if (regad_reg == 5'd2) begin
            regad_word = PHY_ID1;
        end else if (regad_reg == 5'd3) begin
            regad_word = PHY_ID2;
        end
    end

    always_comb begin
        loc_rdata = regs[loc_addr];
        if (loc_addr == 5'd2) begin
            loc_rdata = PHY_ID1;
        end else if (loc_addr == 5'd3) begin
            loc_rdata = PHY_ID2;
        end
    end

    // Per-row write select. MDIO has priority over the local port when both
    // target the same row in the same cycle; different rows both update.
    for (genvar gi = 0; gi < 32; gi++) begin : g_row
        if (gi == 2 || gi == 3) begin : g_ro
            assign row_we[gi]    = 1'b0;
            assign row_wdata[gi] = 16'h0000;
        end else begin : g_rw
            logic mdio_hit;
            logic loc_hit;
            assign mdio_hit      = mdio_we && (regad_reg == 5'(gi));
            assign loc_hit       = loc_we && (loc_addr == 5'(gi));
            assign row_we[gi]    = mdio_hit || loc_hit;
            assign row_wdata[gi] = mdio_hit ? mdio_wdata : loc_wdata;
        end
    end

    always_ff @(posedge clk_25_mhz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (row_we[i]) begin
                    regs[i] <= row_wdata[i];
                end
            end
        end
    end

    always_ff @(posedge clk_25_mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            pre_cnt_reg <= '0;
            bit_cnt_reg <= 5'd0;
            op_msb_reg  <= 1'b0;
            is_read_reg <= 1'b0;
            phyad_reg   <= 5'd0;
            regad_reg   <= 5'd0;
            shift_reg   <= 16'h0000;
            oe_reg      <= 1'b0;
            o_reg       <= 1'b1;
            strobe_reg  <= 1'b0;
            wr_addr_reg <= 5'd0;
            wr_data_reg <= 16'h0000;
        end else begin
            strobe_reg <= mdio_we;
            if (mdio_we) begin
                wr_addr_reg <= regad_reg;
                wr_data_reg <= mdio_wdata;
            end

            case (state_reg)
                S_IDLE: begin
                    // pre_cnt_reg is cleared whenever IDLE is left, so every
                    // frame end or abort needs a fresh preamble.
                    if (mdio_i) begin
                        if (pre_cnt_reg < PRE_MAX) begin
                            pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
                        end
                    end else if (pre_cnt_reg >= PRE_MAX) begin
                        state_reg   <= S_ST2;
                        pre_cnt_reg <= '0;
                    end else begin
                        pre_cnt_reg <= '0;
                    end
                end

                S_ST2: begin
                    bit_cnt_reg <= 5'd0;
                    state_reg   <= mdio_i ? S_OP : S_IDLE;
                end

                S_OP: begin
                    if (bit_cnt_reg == 5'd0) begin
                        op_msb_reg  <= mdio_i;
                        bit_cnt_reg <= 5'd1;
                    end else if (op_msb_reg != mdio_i) begin
                        // 10 = read, 01 = write
                        is_read_reg <= op_msb_reg;
                        bit_cnt_reg <= 5'd0;
                        state_reg   <= S_PHYAD;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end

                S_PHYAD: begin
                    phyad_reg <= {phyad_reg[3:0], mdio_i};
                    if (bit_cnt_reg == 5'd4) begin
                        bit_cnt_reg <= 5'd0;
                        state_reg   <= S_REGAD;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 5'd1;
                    end
                end

                S_REGAD: begin
                    regad_reg <= {regad_reg[3:0], mdio_i};
                    if (bit_cnt_reg == 5'd4) begin
                        bit_cnt_reg <= 5'd0;
                        state_reg   <= S_TA;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 5'd1;
                    end
                end

                S_TA: begin
                    if (is_read_reg) begin
                        // This edge ends TA1 (left undriven) and opens TA2,
                        // which we drive low. The read word is captured here
                        // so later local writes cannot disturb it.
                        if (addr_match) begin
                            oe_reg <= 1'b1;
                            o_reg  <= 1'b0;
                        end
                        shift_reg   <= regad_word;
                        bit_cnt_reg <= 5'd0;
                        state_reg   <= S_RD_DATA;
                    end else if (bit_cnt_reg == 5'd0) begin
                        if (mdio_i) begin
                            bit_cnt_reg <= 5'd1;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end else if (!mdio_i) begin
                        bit_cnt_reg <= 5'd0;
                        state_reg   <= S_WR_DATA;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end

                S_RD_DATA: begin
                    // Mismatched frames run through here too, just without
                    // ever touching the line.
                    if (bit_cnt_reg == 5'd16) begin
                        oe_reg    <= 1'b0;
                        o_reg     <= 1'b1;
                        state_reg <= S_IDLE;
                    end else begin
                        if (addr_match) begin
                            o_reg <= shift_reg[15];
                        end
                        shift_reg   <= {shift_reg[14:0], 1'b0};
                        bit_cnt_reg <= bit_cnt_reg + 5'd1;
                    end
                end

                S_WR_DATA: begin
                    shift_reg <= mdio_wdata;
                    if (bit_cnt_reg == 5'd15) begin
                        state_reg <= S_IDLE;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 5'd1;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_responder.sv
// -----------------------------------------------------------------------------
// tb_mdio_responder
//
// Bench for mdio_responder. Acts as the MDIO master: bit-bangs frames, models
// the pad pull-up, and compares the responder against a register-level model
// (array of 16-bit words plus last-write bookkeeping) derived from the frame
// rules. Directed cases first, then randomized frames and local writes.
// -----------------------------------------------------------------------------
module tb_mdio_responder;

    localparam logic [4:0]  PHY_ADDR = 5'd1;
    localparam logic [15:0] PHY_ID1  = 16'h0007;
    localparam logic [15:0] PHY_ID2  = 16'hC0F1;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam int THR = 1;
`else
    localparam int THR = 32;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_oe = 1'b1;
    logic        m_bit = 1'b0;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_oe;
    logic        wr_strobe;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic [4:0]  loc_addr = 5'd0;
    logic [15:0] loc_rdata;
    logic        loc_we = 1'b0;
    logic [15:0] loc_wdata = 16'h0000;

    // Pad model: master drive, else responder drive, else pull-up.
    assign mdio_i = m_oe ? m_bit : (mdio_oe ? mdio_o : 1'b1);

    always #20 clk = ~clk;

    mdio_responder #(
        .PHY_ADDR    (PHY_ADDR),
        .PHY_ID1     (PHY_ID1),
        .PHY_ID2     (PHY_ID2),
        .PREAMBLE_LEN(32)
    ) dut (
        .clk_25_mhz(clk),
        .rst_n     (rst_n),
        .mdio_i    (mdio_i),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .loc_addr  (loc_addr),
        .loc_rdata (loc_rdata),
        .loc_we    (loc_we),
        .loc_wdata (loc_wdata)
    );

    logic [15:0] model_regs [32];
    logic [4:0]  model_wr_addr;
    logic [15:0] model_wr_data;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [15:0] model_read(input logic [4:0] a);
        if (a == 5'd2) return PHY_ID1;
        if (a == 5'd3) return PHY_ID2;
        return model_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_regs[i] = 16'h0000;
        model_wr_addr = 5'd0;
        model_wr_data = 16'h0000;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic local_write(input logic [4:0] a, input logic [15:0] d);
        loc_addr  = a;
        loc_wdata = d;
        loc_we    = 1'b1;
        @(posedge clk); #1;
        loc_we = 1'b0;
        if (a != 5'd2 && a != 5'd3) model_regs[a] = d;
        chk("loc_rdata", 32'(loc_rdata), 32'(model_read(a)));
        $display("local write reg=%0d data=%h readback=%h", a, d, loc_rdata);
    endtask

    // One complete master frame. collide: local write to the same register on
    // the MDIO accept edge. rst_at: loop index at which reset is pulsed (-1 none).
    task automatic run_frame(input int pre_len, input bit is_read, input logic [4:0] phy,
                             input logic [4:0] ra, input logic [1:0] ta,
                             input logic [15:0] wdata, input bit collide, input int rst_at);
        logic [31:0] frame;
        logic [15:0] rd_exp;
        logic [15:0] got;
        logic [15:0] seen_data;
        logic [15:0] seen_rdata;
        logic [4:0]  seen_addr;
        bit          match;
        bit          exp_wr;
        bit          exp_drive;
        bit          aborted;
        int          strobes;
        int          oe_cyc;
        int          k;

        frame     = {2'b01, (is_read ? 2'b10 : 2'b01), phy, ra, ta, wdata};
        match     = (pre_len >= THR) && (phy == PHY_ADDR);
        exp_drive = match && is_read;
        exp_wr    = match && !is_read && (ta == 2'b10) && (ra != 5'd2) && (ra != 5'd3);
        rd_exp    = model_read(ra);
        loc_addr  = ra;
        got = 16'h0; seen_data = 16'h0; seen_rdata = 16'h0; seen_addr = 5'd0;
        strobes = 0; oe_cyc = 0; aborted = 1'b0;

        for (int i = 0; i < pre_len + 32; i++) begin
            k = i - pre_len;
            if (k < 0) begin
                m_oe = 1'b1; m_bit = 1'b1;
            end else begin
                m_oe  = !(is_read && k >= 14);
                m_bit = frame[31-k];
            end
            if (collide && k == 31) begin
                loc_we = 1'b1; loc_wdata = ~wdata;
            end
            @(posedge clk); #1;
            loc_we = 1'b0;
            if (i == rst_at) begin
                chk("pre_rst_oe", 32'(mdio_oe), 32'(exp_drive));
                rst_n = 1'b0; #1;
                chk("rst_oe", 32'(mdio_oe), 0);
                chk("rst_o", 32'(mdio_o), 1);
                m_oe = 1'b1; m_bit = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                model_reset();
                aborted = 1'b1;
                break;
            end
            if (mdio_oe) oe_cyc++;
            if (wr_strobe) begin
                strobes++;
                seen_addr  = wr_addr;
                seen_data  = wr_data;
                seen_rdata = loc_rdata;
            end
            if (exp_drive) begin
                if (k == 13) chk("ta1_oe", 32'(mdio_oe), 0);
                if (k == 14) begin
                    chk("ta2_oe", 32'(mdio_oe), 1);
                    chk("ta2_o", 32'(mdio_o), 0);
                end
                if (k >= 15 && k <= 30) got[30-k] = mdio_o;
                if (k == 31) begin
                    chk("end_oe", 32'(mdio_oe), 0);
                    chk("end_o", 32'(mdio_o), 1);
                end
            end
        end

        if (aborted) begin
            $display("frame rd=%0d phy=%0d reg=%0d pre=%0d interrupted by reset", is_read, phy, ra, pre_len);
        end else begin
            m_oe = 1'b1; m_bit = 1'b0;
            repeat (4) begin
                @(posedge clk); #1;
                if (mdio_oe) oe_cyc++;
                if (wr_strobe) strobes++;
            end
            chk("oe_cycles", 32'(oe_cyc), exp_drive ? 32'd17 : 32'd0);
            if (exp_drive) chk("rd_data", 32'(got), 32'(rd_exp));
            chk("strobes", 32'(strobes), exp_wr ? 32'd1 : 32'd0);
            if (exp_wr) begin
                model_regs[ra] = wdata;
                model_wr_addr  = ra;
                model_wr_data  = wdata;
                chk("strobe_addr", 32'(seen_addr), 32'(ra));
                chk("strobe_data", 32'(seen_data), 32'(wdata));
                chk("strobe_rdata", 32'(seen_rdata), 32'(wdata));
            end else if (collide && ra != 5'd2 && ra != 5'd3) begin
                model_regs[ra] = ~wdata;
            end
            chk("wr_addr", 32'(wr_addr), 32'(model_wr_addr));
            chk("wr_data", 32'(wr_data), 32'(model_wr_data));
            chk("reg_after", 32'(loc_rdata), 32'(model_read(ra)));
            $display("frame rd=%0d phy=%0d reg=%0d pre=%0d ta=%b wdata=%h rdata=%h strobes=%0d oe_cycles=%0d",
                     is_read, phy, ra, pre_len, ta, wdata, got, strobes, oe_cyc);
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_mdio_oe", 32'(mdio_oe), 0);
        chk("rst_mdio_o", 32'(mdio_o), 1);
        chk("rst_strobe", 32'(wr_strobe), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        loc_addr = 5'd2; #1;
        chk("rst_reg2", 32'(loc_rdata), 32'(PHY_ID1));
        loc_addr = 5'd3; #1;
        chk("rst_reg3", 32'(loc_rdata), 32'(PHY_ID2));
        loc_addr = 5'd4; #1;
        chk("rst_reg4", 32'(loc_rdata), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_frame(32, 1'b0, 5'd1, 5'd4, 2'b10, 16'h01E1, 1'b0, -1);  // write reg 4
        run_frame(32, 1'b1, 5'd1, 5'd2, 2'b10, 16'h0000, 1'b0, -1);  // read ID1
        run_frame(32, 1'b1, 5'd3, 5'd2, 2'b10, 16'h0000, 1'b0, -1);  // wrong PHY
        run_frame(31, 1'b0, 5'd1, 5'd4, 2'b10, 16'hBEEF, 1'b0, -1);  // short preamble
        run_frame(1,  1'b0, 5'd1, 5'd4, 2'b10, 16'h1234, 1'b0, -1);  // one-bit preamble
        run_frame(32, 1'b0, 5'd1, 5'd3, 2'b10, 16'hFFFF, 1'b0, -1);  // read-only reg
        local_write(5'd3, 16'h5555);
        run_frame(32, 1'b0, 5'd1, 5'd5, 2'b11, 16'h0000, 1'b0, -1);  // bad TA
        run_frame(32, 1'b0, 5'd1, 5'd6, 2'b10, 16'hA5A5, 1'b1, -1);  // MDIO vs local
        local_write(5'd7, 16'h3C3C);
        run_frame(32, 1'b1, 5'd1, 5'd7, 2'b10, 16'h0000, 1'b0, -1);
        run_frame(32, 1'b0, 5'd1, 5'd4, 2'b10, 16'h8001, 1'b0, -1);
        run_frame(32, 1'b1, 5'd1, 5'd4, 2'b10, 16'h0000, 1'b0, 32 + 19);  // reset at 5th data bit
        loc_addr = 5'd4; #1;
        chk("post_rst_reg4", 32'(loc_rdata), 0);
        chk("post_rst_wr_addr", 32'(wr_addr), 0);
        chk("post_rst_oe", 32'(mdio_oe), 0);
        repeat (2) @(posedge clk);
        #1;
        run_frame(32, 1'b0, 5'd1, 5'd4, 2'b10, 16'h0F0F, 1'b0, -1);
        run_frame(32, 1'b1, 5'd1, 5'd4, 2'b10, 16'h0000, 1'b0, -1);

        for (int r = 0; r < 30; r++) begin
            bit          rd;
            logic [4:0]  phy;
            logic [4:0]  ra;
            logic [15:0] wd;
            int          pre;
            if ($urandom_range(0, 2) == 0)
                local_write(5'($urandom_range(0, 31)), 16'($urandom));
            rd  = 1'($urandom_range(0, 1));
            phy = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(2, 31)) : PHY_ADDR;
            ra  = 5'($urandom_range(0, 31));
            wd  = 16'($urandom);
            pre = (THR == 1) ? int'($urandom_range(1, 40)) : int'($urandom_range(28, 40));
            run_frame(pre, rd, phy, ra, 2'b10, wd, 1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
